// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline register stages: state encoding and default payload constants.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_e;

   localparam int unsigned PIPE_W_DEFAULT = 32;
   localparam logic [PIPE_W_DEFAULT-1:0] PIPE_NOP_DEFAULT = '0;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready payload stream between pipeline stages; master drives valid/data, slave drives ready.
interface pipe_stage_skid_if #(
   parameter int unsigned WIDTH = 32
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter, sticks at all-ones; shared by pipeline stages for performance counters.
module pipe_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with valid/ready handshake, stall, flush-to-bubble, optional 2-entry skid
// buffer (registered ready) and a saturating back-pressure cycle counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH     = PIPE_W_DEFAULT,
   parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(PIPE_NOP_DEFAULT),
   parameter bit               SKID      = 1'b1,
   parameter int unsigned      CNT_W     = 16
) (
   input  logic               clk,
   input  logic               clrn,
   pipe_stage_skid_if.slave   up,
   pipe_stage_skid_if.master  dn,
   input  logic               stall,
   input  logic               flush,
   output logic [CNT_W-1:0]   stall_cnt
);

   pipe_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             out_valid;
   logic             ready_c;
   logic             accept;
   logic             drain;

   assign out_valid = (state_q != ST_EMPTY);
   assign accept    = up.valid & ready_c;
   assign drain     = out_valid & dn.ready & ~stall;

   // Next-state and payload movement; flush overrides everything including a same-cycle accept.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_ONE;
                  main_d  = up.data;
               end
            end
            ST_ONE: begin
               if (accept) begin
                  if (drain) begin
                     main_d = up.data;
                  end else if (SKID) begin
                     state_d = ST_TWO;
                     skid_d  = up.data;
                  end
               end else if (drain) begin
                  state_d = ST_EMPTY;
                  main_d  = NOP_VALUE;
               end
            end
            ST_TWO: begin
               if (drain) begin
                  state_d = ST_ONE;
                  main_d  = skid_q;
                  skid_d  = NOP_VALUE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = NOP_VALUE;
               skid_d  = NOP_VALUE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= ST_EMPTY;
         main_q  <= NOP_VALUE;
         skid_q  <= NOP_VALUE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Skid build registers ready from the next state; single-entry build passes ready through.
   if (SKID) begin : g_skid
      logic ready_q;
      always_ff @(posedge clk or negedge clrn) begin
         if (!clrn) ready_q <= 1'b1;
         else       ready_q <= (state_d != ST_TWO);
      end
      assign ready_c = ready_q;
   end else begin : g_noskid
      assign ready_c = ~out_valid | (dn.ready & ~stall);
   end

   assign up.ready = ready_c;
   assign dn.valid = out_valid;
   assign dn.data  = main_q;

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .clrn  (clrn),
      .inc_i (out_valid & ~drain),
      .cnt_o (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a skid build (CNT_W=16) and a single-entry build (CNT_W=2)
// share stimulus; sel picks which one the reference model tracks.
module tb_pipe_stage_skid;

   localparam int unsigned W   = 32;
   localparam logic [W-1:0] NOP = 32'hDEAD_0000;

   logic         clk;
   logic         clrn;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         out_ready;
   logic         stall;
   logic         flush;
   logic         sel;

   logic [15:0]  st_cnt1;
   logic [1:0]   st_cnt2;

   int           n_vec;
   int           n_err;

   logic [W-1:0] exp_q[$];
   logic [15:0]  cnt_m;

   pipe_stage_skid_if #(.WIDTH(W)) up1 ();
   pipe_stage_skid_if #(.WIDTH(W)) dn1 ();
   pipe_stage_skid_if #(.WIDTH(W)) up2 ();
   pipe_stage_skid_if #(.WIDTH(W)) dn2 ();

   assign up1.valid = in_valid;
   assign up1.data  = in_data;
   assign dn1.ready = out_ready;
   assign up2.valid = in_valid;
   assign up2.data  = in_data;
   assign dn2.ready = out_ready;

   pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(16)) u_dut_skid (
      .clk (clk), .clrn (clrn), .up (up1.slave), .dn (dn1.master),
      .stall (stall), .flush (flush), .stall_cnt (st_cnt1)
   );

   pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP), .SKID(1'b0), .CNT_W(2)) u_dut_noskid (
      .clk (clk), .clrn (clrn), .up (up2.slave), .dn (dn2.master),
      .stall (stall), .flush (flush), .stall_cnt (st_cnt2)
   );

   wire          obs_ov  = sel ? dn2.valid : dn1.valid;
   wire          obs_ir  = sel ? up2.ready : up1.ready;
   wire [W-1:0]  obs_od  = sel ? dn2.data  : dn1.data;
   wire [15:0]   obs_cnt = sel ? 16'(st_cnt2) : st_cnt1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t sel=%0d)", tag, obs, exp, $time, sel);
      end
   endtask

   // Reference model: FIFO occupancy, handshake and stall counter, evaluated mid-cycle.
   always @(negedge clk) begin
      logic        m_valid, m_ready, m_drain, m_accept;
      logic [15:0] cnt_max;
      if (!clrn) begin
         exp_q.delete();
         cnt_m = '0;
         check_val("rst_out_valid", 32'(obs_ov), 32'd0);
         check_val("rst_out_data", obs_od, NOP);
         check_val("rst_stall_cnt", 32'(obs_cnt), 32'd0);
         check_val("rst_in_ready", 32'(obs_ir), 32'd1);
      end else begin
         cnt_max  = sel ? 16'd3 : 16'hFFFF;
         m_valid  = (exp_q.size() != 0);
         m_ready  = sel ? (!m_valid || (out_ready && !stall)) : (exp_q.size() < 2);
         m_drain  = m_valid && out_ready && !stall;
         m_accept = in_valid && m_ready;
         check_val("out_valid", 32'(obs_ov), 32'(m_valid));
         check_val("in_ready", 32'(obs_ir), 32'(m_ready));
         check_val("stall_cnt", 32'(obs_cnt), 32'(cnt_m));
         if (!m_valid) check_val("bubble_data", obs_od, NOP);
         if (m_drain)  check_val("out_data", obs_od, exp_q[0]);
         if (m_valid && !m_drain && cnt_m != cnt_max) cnt_m = cnt_m + 16'd1;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (m_drain)  void'(exp_q.pop_front());
            if (m_accept) exp_q.push_back(in_data);
         end
      end
   end

   task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy, input logic st,
                      input logic fl);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      stall     = st;
      flush     = fl;
   endtask

   task automatic do_reset(input logic s);
      @(posedge clk);
      #1;
      clrn = 1'b0;
      sel  = s;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clrn = 1'b1;
   endtask

   task automatic stream_test();
      for (int i = 0; i < 8; i++) cyc(1'b1, W'(32'h11 + i), 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; cnt_m = '0;
      clrn = 1'b0; sel = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;

      // Skid build: back-to-back stream.
      do_reset(1'b0);
      stream_test();
      check_val("stream_cnt", 32'(st_cnt1), 32'd0);

      // Back-pressure: A held, B in skid, C refused until space frees.
      cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_val("full_in_ready", 32'(up1.ready), 32'd0);
      check_val("full_head", dn1.data, 32'hA);
      cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Stall freezes the head for 3 cycles.
      do_reset(1'b0);
      cyc(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
      repeat (3) begin
         cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
         @(negedge clk);
         check_val("stall_frozen", dn1.data, 32'h33);
      end
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_val("stall_cnt3", 32'(st_cnt1), 32'd3);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Flush in TWO with a same-cycle input.
      do_reset(1'b0);
      cyc(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h45, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hEE, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_val("flush_valid", 32'(dn1.valid), 32'd0);
      check_val("flush_data", dn1.data, NOP);
      check_val("flush_ready", 32'(up1.ready), 32'd1);
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset while in TWO.
      cyc(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h67, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      clrn = 1'b0;
      #1;
      check_val("arst_valid", 32'(dn1.valid), 32'd0);
      check_val("arst_cnt", 32'(st_cnt1), 32'd0);
      check_val("arst_ready", 32'(up1.ready), 32'd1);

      // Single-entry build with a 2-bit counter.
      do_reset(1'b1);
      stream_test();
      check_val("noskid_stream_cnt", 32'(st_cnt2), 32'd0);
      cyc(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
      repeat (6) cyc(1'b1, 32'h56, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check_val("sat_cnt", 32'(st_cnt2), 32'd3);
      check_val("noskid_stall_ready", 32'(up2.ready), 32'd0);
      cyc(1'b1, 32'h56, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_val("sat_hold", 32'(st_cnt2), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
